// File: rtl/plab5_mcore_secure_mem_responder_pkg.sv
// Shared mcore memory message definitions: type encodings, control-field widths
// and small helpers used by the secure memory responder.
package plab5_mcore_secure_mem_responder_pkg;

  typedef enum logic [2:0] {
    MEM_READ  = 3'h0,
    MEM_WRITE = 3'h1
  } mem_type_e;

  localparam int c_type_nbits = 3;

  // Full message widths; the control part is these minus the data field.
  function automatic int mem_req_msg_nbits(int o, int a, int d);
    return c_type_nbits + o + a + $clog2(d / 8) + d;
  endfunction

  function automatic int mem_resp_msg_nbits(int o, int d);
    return c_type_nbits + o + $clog2(d / 8) + d;
  endfunction

  function automatic logic [7:0] sat_inc8(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/plab5_mcore_secure_mem_responder_resp_queue2.sv
// Two-entry val/rdy response FIFO with asynchronous active-low reset.
// The producer qualifies enq_val with !full itself; there is no bypass path.
module plab5_mcore_resp_queue2 #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic               full
);

  logic [1:0]         count_q, count_d;
  logic               head_q, head_d;
  logic [p_nbits-1:0] entry_q [2];
  logic               deq_go;
  logic               tail;

  assign full    = (count_q == 2'd2);
  assign deq_val = (count_q != 2'd0);
  assign deq_go  = deq_val && deq_rdy;
  assign tail    = head_q ^ count_q[0];
  assign deq_msg = entry_q[head_q];

  always_comb begin
    count_d = count_q + {1'b0, enq_val} - {1'b0, deq_go};
    head_d  = deq_go ? ~head_q : head_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in count_q.
  always_ff @(posedge clk) begin
    if (enq_val) entry_q[tail] <= enq_msg;
  end

endmodule

// File: rtl/plab5_mcore_secure_mem_responder.sv
// Memory-side responder with a domain-checked secure region; every accepted
// request, allowed or denied, produces exactly one response.
module plab5_mcore_secure_mem_responder
  import plab5_mcore_secure_mem_responder_pkg::*;
#(
  parameter int                      p_opaque_nbits = 8,
  parameter int                      p_addr_nbits   = 32,
  parameter int                      p_data_nbits   = 32,
  parameter int                      p_num_words    = 256,
  parameter logic [p_addr_nbits-1:0] p_secure_base  = 'h200,
  localparam int c_req_cnbits  = mem_req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits) - p_data_nbits,
  localparam int c_resp_cnbits = mem_resp_msg_nbits(p_opaque_nbits, p_data_nbits) - p_data_nbits
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [c_req_cnbits-1:0]  req_control,
  input  logic [p_data_nbits-1:0]  req_data,
  input  logic                     req_domain,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [c_resp_cnbits-1:0] resp_control,
  output logic [p_data_nbits-1:0]  resp_data,
  output logic                     resp_domain,
  output logic [7:0]               viol_count
);

  localparam int c_len_nbits = $clog2(p_data_nbits / 8);
  localparam int c_idx_nbits = $clog2(p_num_words);
  localparam int c_q_nbits   = c_resp_cnbits + p_data_nbits + 1;
  localparam logic [p_addr_nbits-1:0] c_range_limit = p_addr_nbits'(4 * p_num_words);

  logic [c_type_nbits-1:0]   req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [p_addr_nbits-1:0]   req_addr;
  logic [c_len_nbits-1:0]    req_len;
  logic [c_idx_nbits-1:0]    idx;
  logic                      req_go, in_range, denied, allowed, is_read, is_write;
  logic [p_data_nbits-1:0]   rd_data;
  logic [p_data_nbits-1:0]   mem_array [p_num_words];
  logic [7:0]                viol_count_q, viol_count_d;
  logic                      q_full;
  logic [c_q_nbits-1:0]      q_deq_msg;

  assign {req_type, req_opaque, req_addr, req_len} = req_control;

  assign idx      = req_addr[c_idx_nbits+1:2];
  assign req_go   = req_val && req_rdy;
  assign in_range = (req_addr < c_range_limit);
  assign denied   = (req_addr >= p_secure_base) && !req_domain;
  assign allowed  = in_range && !denied;
  assign is_read  = (req_type == MEM_READ);
  assign is_write = (req_type == MEM_WRITE);
  assign rd_data  = (is_read && allowed) ? mem_array[idx] : '0;

  always_ff @(posedge clk) begin
    if (req_go && is_write && allowed) mem_array[idx] <= req_data;
  end

  always_comb begin
    viol_count_d = viol_count_q;
    if (req_go && (is_read || is_write) && denied) viol_count_d = sat_inc8(viol_count_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) viol_count_q <= 8'd0;
    else        viol_count_q <= viol_count_d;
  end

  assign viol_count = viol_count_q;
  assign req_rdy    = !q_full;

  plab5_mcore_resp_queue2 #(.p_nbits(c_q_nbits)) u_resp_q (
    .clk     (clk),
    .reset   (reset),
    .enq_val (req_go),
    .enq_msg ({req_type, req_opaque, req_len, rd_data, req_domain}),
    .deq_val (resp_val),
    .deq_rdy (resp_rdy),
    .deq_msg (q_deq_msg),
    .full    (q_full)
  );

  assign {resp_control, resp_data, resp_domain} = q_deq_msg;

endmodule

// File: tb/tb_plab5_mcore_secure_mem_responder.sv
// Randomized scoreboard bench for the secure memory responder.
module tb_plab5_mcore_secure_mem_responder;

  typedef struct packed {
    logic [12:0] ctrl;
    logic [31:0] data;
    logic        dom;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val, req_rdy, req_domain;
  logic [44:0] req_control;
  logic [31:0] req_data;
  logic        resp_val, resp_rdy, resp_domain;
  logic [12:0] resp_control;
  logic [31:0] resp_data;
  logic [7:0]  viol_count;

  resp_t       sb[$];
  logic [31:0] mdl_mem [256];
  int          mdl_viol;
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;

  always #5 clk = ~clk;

  plab5_mcore_secure_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_control  (req_control),
    .req_data     (req_data),
    .req_domain   (req_domain),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_control (resp_control),
    .resp_data    (resp_data),
    .resp_domain  (resp_domain),
    .viol_count   (viol_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // resp_rdy policy: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    resp_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       resp_rdy = 1'b1;
        1:       resp_rdy = 1'b0;
        default: resp_rdy = ($urandom % 2) != 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset && resp_val && resp_rdy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp actual=%0h expected=none", {resp_control, resp_data, resp_domain});
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp", {18'd0, resp_control, resp_data, resp_domain}, {18'd0, e});
      end
    end
  end

  // Issue one request; the reference outcome is computed at the acceptance point.
  task automatic send(input logic [2:0] t, input logic [31:0] addr, input logic [31:0] wd,
                      input logic dom, input logic [7:0] opq, input logic [1:0] len);
    int    n = 0;
    resp_t r;
    bit    inr, den, ok;
    req_val = 1'b1; req_control = {t, opq, addr, len}; req_data = wd; req_domain = dom;
    @(negedge clk);
    while (!req_rdy && n < 200) begin n++; @(negedge clk); end
    if (!req_rdy) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout actual=req_rdy_low expected=accept addr=%0h", addr);
    end else begin
      inr = addr < 32'h400;
      den = (addr >= 32'h200) && !dom;
      ok  = inr && !den;
      r.ctrl = {t, opq, len};
      r.dom  = dom;
      r.data = 32'd0;
      if (t == 3'd0 && ok) r.data = mdl_mem[addr[9:2]];
      if (t == 3'd1 && ok) mdl_mem[addr[9:2]] = wd;
      if ((t == 3'd0 || t == 3'd1) && den && mdl_viol < 255) mdl_viol++;
      sb.push_back(r);
    end
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin n++; @(negedge clk); end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    logic        d;
    reset = 1'b0; req_val = 1'b0; req_control = '0; req_data = '0; req_domain = 1'b0;
    mdl_viol = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_val", resp_val, 0);
    chk("rst_viol", viol_count, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_rdy", req_rdy, 1);

    for (int i = 0; i < 256; i++)
      send(3'd1, i * 4, 32'hA5A5A5A5 ^ (i * 32'h01010101), 1'b1, 8'(i), 2'd3);
    drain();

    // secure write then read
    send(3'd1, 32'h204, 32'hDEADBEEF, 1'b1, 8'h11, 2'd0);
    chk("lat_write", resp_val, 1);
    drain();
    send(3'd0, 32'h204, 32'h0, 1'b1, 8'h12, 2'd0);
    chk("lat_read", resp_val, 1);
    drain();
    chk("viol_t1", viol_count, 0);

    // non-secure access to secure region
    send(3'd1, 32'h208, 32'h12345678, 1'b0, 8'h21, 2'd0);
    send(3'd0, 32'h208, 32'h0, 1'b1, 8'h22, 2'd0);
    send(3'd0, 32'h208, 32'h0, 1'b0, 8'h23, 2'd0);
    drain();
    chk("viol_t2", viol_count, 2);

    // non-secure access below the base
    send(3'd1, 32'h010, 32'hCAFEF00D, 1'b0, 8'h31, 2'd0);
    send(3'd0, 32'h010, 32'h0, 1'b0, 8'h32, 2'd0);
    drain();
    chk("viol_t3", viol_count, 2);

    // backpressure
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(3'd0, 32'h010, 32'h0, 1'b0, 8'h41, 2'd1);
    send(3'd0, 32'h204, 32'h0, 1'b1, 8'h42, 2'd2);
    @(negedge clk);
    chk("bp_req_rdy_full", req_rdy, 0);
    repeat (3) @(negedge clk);
    chk("bp_req_rdy_hold", req_rdy, 0);
    chk("bp_resp_val_hold", resp_val, 1);
    chk("bp_resp_data_hold", resp_data, 32'hCAFEF00D);
    rdy_mode = 0;
    @(posedge clk); #1;
    send(3'd0, 32'h208, 32'h0, 1'b1, 8'h43, 2'd3);
    drain();

    // randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 250; i++) begin
      t = (($urandom % 8) < 6) ? 3'($urandom % 2) : 3'(2 + ($urandom % 6));
      case ($urandom % 4)
        0:       a = $urandom_range(0, 32'h1FF);
        1:       a = $urandom_range(32'h200, 32'h3FF);
        2:       a = $urandom_range(32'h400, 32'h7FF);
        default: a = $urandom;
      endcase
      d = ($urandom % 2) != 0;
      if (t > 3'd1) d = 1'b1;
      send(t, a, $urandom, d, 8'($urandom), 2'($urandom));
      if (($urandom % 4) == 0) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    drain();
    chk("viol_random", viol_count, 64'(mdl_viol));

    // saturation and out of range
    repeat (300) send(3'd0, 32'h300, 32'h0, 1'b0, 8'h55, 2'd0);
    drain();
    chk("viol_sat", viol_count, 8'hFF);
    send(3'd0, 32'h400, 32'h0, 1'b1, 8'h66, 2'd0);
    drain();
    chk("viol_oor", viol_count, 8'hFF);

    // asynchronous reset with two responses queued
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(3'd0, 32'h204, 32'h0, 1'b1, 8'h71, 2'd0);
    send(3'd0, 32'h010, 32'h0, 1'b0, 8'h72, 2'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_resp_val", resp_val, 0);
    chk("arst_viol", viol_count, 0);
    sb.delete();
    mdl_viol = 0;
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("arst_req_rdy", req_rdy, 1);
    send(3'd0, 32'h204, 32'h0, 1'b1, 8'h73, 2'd0);
    send(3'd0, 32'h010, 32'h0, 1'b0, 8'h74, 2'd0);
    drain();
    chk("arst_viol_after", viol_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
